// File: rtl/async_fifo_pkg.sv
// Gray-code helpers shared by both clock domains of the dual-clock FIFO.
// Functions work on a fixed maximum width; the caller passes the live width, and bits above it are masked.
package async_fifo_pkg;

  localparam int GRAY_MAX_W = 32;
  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  function automatic gray_word_t width_mask(input int w);
    gray_word_t m;
    m = '1;
    return m >> (GRAY_MAX_W - w);
  endfunction

  function automatic gray_word_t bin2gray(input gray_word_t b, input int w);
    return (b ^ (b >> 1)) & width_mask(w);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t g, input int w);
    gray_word_t gm;
    gray_word_t b;
    gm = g & width_mask(w);
    b  = gm;
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gm[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_gray_if.sv
// FIFO write/read handshake bundle. master = producer/consumer side, slave = FIFO.
// When ASYNC_FIFO_ERR_FLAGS_EN is defined, the bundle also carries the sticky overflow/underflow flags.
interface async_fifo_gray_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wr_level;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   rd_level;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;

  modport master (output wr_en, wdata, rd_en,
                  input  full, almost_full, wr_level, rdata, rvalid, empty, almost_empty, rd_level,
                         overflow, underflow);
  modport slave  (input  wr_en, wdata, rd_en,
                  output full, almost_full, wr_level, rdata, rvalid, empty, almost_empty, rd_level,
                         overflow, underflow);
`else
  modport master (output wr_en, wdata, rd_en,
                  input  full, almost_full, wr_level, rdata, rvalid, empty, almost_empty, rd_level);
  modport slave  (input  wr_en, wdata, rd_en,
                  output full, almost_full, wr_level, rdata, rvalid, empty, almost_empty, rd_level);
`endif
endinterface

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer entering a new clock domain.
// Latency is STAGES clocks of clk; it applies no backpressure and resets to zero asynchronously.
module gray_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];
endmodule

// File: rtl/async_fifo_gray.sv
// Dual-clock Gray-pointer FIFO: read latency 1 rd_clk; full/empty drop wr_en/rd_en and release pessimistically.
// Defining ASYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs for requests that were dropped.
module async_fifo_gray
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_LEVEL    = 12,
  parameter int AE_LEVEL    = 4
) (
  input logic              wr_clk,
  input logic              rd_clk,
  input logic              rst,
  async_fifo_gray_if.slave bus
);
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef logic [PW-1:0] ptr_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  ptr_t wbin, wgray, wbin_next, wgray_next, rq_gray, wr_level_next, wr_level_q;
  logic wr_ok, full_q, full_next, almost_full_q;

  ptr_t rbin, rgray, rbin_next, rgray_next, wq_gray, rd_level_next, rd_level_q;
  logic rd_ok, empty_q, empty_next, almost_empty_q, rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write domain
  assign wr_ok         = bus.wr_en && !full_q;
  assign wbin_next     = wbin + ptr_t'(wr_ok);
  assign wgray_next    = ptr_t'(bin2gray(gray_word_t'(wbin_next), PW));
  assign full_next     = (wgray_next == {~rq_gray[PW-1:PW-2], rq_gray[PW-3:0]});
  assign wr_level_next = wbin_next - ptr_t'(gray2bin(gray_word_t'(rq_gray), PW));

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      wbin          <= '0;
      wgray         <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      wr_level_q    <= '0;
    end else begin
      wbin          <= wbin_next;
      wgray         <= wgray_next;
      full_q        <= full_next;
      wr_level_q    <= wr_level_next;
      almost_full_q <= (wr_level_next >= ptr_t'(AF_LEVEL));
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_ok) mem[wbin[ADDR_WIDTH-1:0]] <= bus.wdata;
  end

  gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_rd2wr (
    .clk (wr_clk),
    .rst (rst),
    .d   (rgray),
    .q   (rq_gray)
  );

  // Read domain
  assign rd_ok         = bus.rd_en && !empty_q;
  assign rbin_next     = rbin + ptr_t'(rd_ok);
  assign rgray_next    = ptr_t'(bin2gray(gray_word_t'(rbin_next), PW));
  assign empty_next    = (rgray_next == wq_gray);
  assign rd_level_next = ptr_t'(gray2bin(gray_word_t'(wq_gray), PW)) - rbin_next;

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      rbin           <= '0;
      rgray          <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      rd_level_q     <= '0;
      rvalid_q       <= 1'b0;
      rdata_q        <= '0;
    end else begin
      rbin           <= rbin_next;
      rgray          <= rgray_next;
      empty_q        <= empty_next;
      rd_level_q     <= rd_level_next;
      almost_empty_q <= (rd_level_next <= ptr_t'(AE_LEVEL));
      rvalid_q       <= rd_ok;
      if (rd_ok) rdata_q <= mem[rbin[ADDR_WIDTH-1:0]];
    end
  end

  gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_wr2rd (
    .clk (rd_clk),
    .rst (rst),
    .d   (wgray),
    .q   (wq_gray)
  );

  assign bus.full         = full_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.wr_level     = wr_level_q;
  assign bus.empty        = empty_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.rd_level     = rd_level_q;
  assign bus.rvalid       = rvalid_q;
  assign bus.rdata        = rdata_q;

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else if (bus.wr_en && full_q) overflow_q <= 1'b1;
  end

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) underflow_q <= 1'b0;
    else if (bus.rd_en && empty_q) underflow_q <= 1'b1;
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule
